loopyv_mem_stage: RTL

LOOPYV_MEM_STAGE -- requirements
Module: loopyv_mem_stage

---
 rtl/loopyv_mem_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/loopyv_mem_stage.sv
// LoopyV memory stage: turns EX/MEM entries into data-memory requests and registered MEM/WB entries.
// Optional misaligned-access trap is compiled in with `define LOOPYV_MISALIGN_CHECK_EN.
module loopyv_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exValid,
   output logic        exReady,
   input  logic [4:0]  exRdAddr,
   input  logic        exRdWriteEn,
   input  logic [1:0]  exDestinationSelect,
   input  logic [31:0] exPc,
   input  logic [31:0] exRdWriteData,
   input  logic [31:0] exStoreData,
   input  logic        exMemRead,
   input  logic        exMemWrite,
   input  logic [2:0]  exMemOp,
   input  logic        exIsCompressed,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [3:0]  dmemBe,
   output logic [31:0] dmemWdata,
   input  logic        dmemReady,
   input  logic        dmemRvalid,
   input  logic [31:0] dmemRdata,
   output logic        wbValid,
   output logic [4:0]  wbRdAddr,
   output logic        wbRdWriteEn,
   output logic [31:0] wbRdWriteData,
   output logic        memMisaligned,
   output logic [31:0] misalignAddr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   function automatic logic [3:0] access_be(input logic [2:0] op, input logic [1:0] a);
      case (op[1:0])
         2'b00:   access_be = 4'b0001 << a;
         2'b01:   access_be = 4'b0011 << {a[1], 1'b0};
         default: access_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] d);
      case (op[1:0])
         2'b00:   store_lanes = {4{d[7:0]}};
         2'b01:   store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                                input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{a, 3'b000} +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         3'b000:  load_extract = {{24{b[7]}}, b};
         3'b001:  load_extract = {{16{h[15]}}, h};
         3'b100:  load_extract = {24'd0, b};
         3'b101:  load_extract = {16'd0, h};
         default: load_extract = rdata;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        rd_we_q, rd_we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  mem_op_q, mem_op_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
   logic        wb_we_q, wb_we_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic ex_accept;
   logic ex_is_mem;
   logic ex_misaligned;

   assign ex_accept = exValid && (state_q == IDLE);
   assign ex_is_mem = exMemRead || exMemWrite;

`ifdef LOOPYV_MISALIGN_CHECK_EN
   assign ex_misaligned = ((exMemOp[1:0] == 2'b01) && exRdWriteData[0]) ||
                          ((exMemOp[1:0] == 2'b10) && (exRdWriteData[1:0] != 2'b00));
`else
   assign ex_misaligned = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      rd_we_d      = rd_we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      is_load_d    = is_load_q;
      mem_op_d     = mem_op_q;
      wb_valid_d   = 1'b0;
      wb_rd_addr_d = wb_rd_addr_q;
      wb_we_d      = wb_we_q;
      wb_data_d    = wb_data_q;
      case (state_q)
         IDLE: begin
            if (exValid) begin
               if (!ex_is_mem) begin
                  wb_valid_d   = 1'b1;
                  wb_rd_addr_d = exRdAddr;
                  wb_we_d      = exRdWriteEn;
                  if (exDestinationSelect == 2'b10)
                     wb_data_d = exPc + (exIsCompressed ? 32'd2 : 32'd4);
                  else
                     wb_data_d = exRdWriteData;
               end else if (ex_misaligned) begin
                  // Trapped access retires immediately without touching memory
                  wb_valid_d   = 1'b1;
                  wb_rd_addr_d = exRdAddr;
                  wb_we_d      = 1'b0;
                  wb_data_d    = '0;
               end else begin
                  rd_addr_d = exRdAddr;
                  rd_we_d   = exRdWriteEn;
                  addr_d    = exRdWriteData;
                  wdata_d   = store_lanes(exMemOp, exStoreData);
                  be_d      = access_be(exMemOp, exRdWriteData[1:0]);
                  is_load_d = exMemRead;
                  mem_op_d  = exMemOp;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            if (dmemReady) begin
               if (is_load_q) begin
                  state_d = WAIT;
               end else begin
                  state_d      = IDLE;
                  wb_valid_d   = 1'b1;
                  wb_rd_addr_d = rd_addr_q;
                  wb_we_d      = 1'b0;
                  wb_data_d    = '0;
               end
            end
         end
         WAIT: begin
            if (dmemRvalid) begin
               state_d      = IDLE;
               wb_valid_d   = 1'b1;
               wb_rd_addr_d = rd_addr_q;
               wb_we_d      = rd_we_q;
               wb_data_d    = load_extract(mem_op_q, addr_q[1:0], dmemRdata);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rd_addr_q    <= '0;
         rd_we_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         is_load_q    <= 1'b0;
         mem_op_q     <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_addr_q <= '0;
         wb_we_q      <= 1'b0;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         rd_we_q      <= rd_we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         is_load_q    <= is_load_d;
         mem_op_q     <= mem_op_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_addr_q <= wb_rd_addr_d;
         wb_we_q      <= wb_we_d;
         wb_data_q    <= wb_data_d;
      end
   end

`ifdef LOOPYV_MISALIGN_CHECK_EN
   logic        mis_q, mis_d;
   logic [31:0] mis_addr_q, mis_addr_d;

   always_comb begin
      mis_d      = ex_accept && ex_is_mem && ex_misaligned;
      mis_addr_d = mis_addr_q;
      if (mis_d)
         mis_addr_d = exRdWriteData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign memMisaligned = mis_q;
   assign misalignAddr  = mis_addr_q;
`else
   assign memMisaligned = 1'b0;
   assign misalignAddr  = '0;
`endif

   // Request fields are only driven while a request is outstanding
   assign exReady       = (state_q == IDLE);
   assign dmemReq       = (state_q == REQ);
   assign dmemWe        = dmemReq && !is_load_q;
   assign dmemAddr      = dmemReq ? {addr_q[31:2], 2'b00} : '0;
   assign dmemBe        = dmemReq ? be_q : '0;
   assign dmemWdata     = dmemWe ? wdata_q : '0;
   assign wbValid       = wb_valid_q;
   assign wbRdAddr      = wb_rd_addr_q;
   assign wbRdWriteEn   = wb_we_q;
   assign wbRdWriteData = wb_data_q;

endmodule
